// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output sprite ROM among NREQ renderers.
// Combinational grant, fixed 2-cycle request-to-data latency; losers hold i_req until granted.
module sprite_rom_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 806
) (
  input  logic                   i_clk2,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  output logic [NREQ-1:0]        o_gnt,
  output logic [ADDR_W-1:0]      o_rom_addr,
  input  logic [DATA_W-1:0]      i_rom_data,
  output logic [NREQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     win_idx;
  logic              win_vld;
  logic [ADDR_W-1:0] win_addr;
  logic              win_oob;

  logic              s1_vld;
  logic [PW-1:0]     s1_idx;
  logic              s1_oob;

  logic              s2_oob;
  logic [DATA_W-1:0] rdata_hold;

  // Scan requesters starting at ptr, wrapping mod NREQ; first active one wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!win_vld && i_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_addr = i_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_oob  = (32'(win_addr) >= DEPTH);

  always_comb begin
    o_gnt = '0;
    if (win_vld && !i_rst) begin
      o_gnt[win_idx] = 1'b1;
    end
  end

  // Stage 1: address to ROM plus the tag that follows it down the pipe.
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      s1_vld     <= 1'b0;
      s1_idx     <= '0;
      s1_oob     <= 1'b0;
      o_rom_addr <= '0;
    end else begin
      s1_vld <= win_vld;
      if (win_vld) begin
        ptr        <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        s1_idx     <= win_idx;
        s1_oob     <= win_oob;
        o_rom_addr <= win_oob ? '0 : win_addr;
      end
    end
  end

  // Stage 2: tag lines up with the ROM's registered output.
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      o_rvalid   <= '0;
      s2_oob     <= 1'b0;
      rdata_hold <= '0;
    end else begin
      o_rvalid <= '0;
      if (s1_vld) begin
        o_rvalid[s1_idx] <= 1'b1;
        s2_oob           <= s1_oob;
      end
      if (|o_rvalid) begin
        rdata_hold <= s2_oob ? '0 : i_rom_data;
      end
    end
  end

  // ROM data is already registered inside the ROM; between reads the last byte is held.
  always_comb begin
    o_rdata = rdata_hold;
    if (|o_rvalid) begin
      o_rdata = s2_oob ? '0 : i_rom_data;
    end
  end

  assign o_err = (|o_rvalid) & s2_oob;

  a_gnt_onehot : assert property (@(posedge i_clk2) disable iff (i_rst) $onehot0(o_gnt));
  a_gnt_req    : assert property (@(posedge i_clk2) disable iff (i_rst) (o_gnt & ~i_req) == '0);
  a_rv_onehot  : assert property (@(posedge i_clk2) disable iff (i_rst) $onehot0(o_rvalid));

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed table, hand sequences and random traffic vs a queue model.
module tb_sprite_rom_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int DEPTH = 806;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*AW-1:0] addr_bus = '0;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_q = '0;
  logic [NREQ-1:0]   rvalid;
  logic [DW-1:0]     rdata;
  logic              err;

  logic [DW-1:0] mem [1024];

  int n_chk  = 0;
  int n_pass = 0;

  sprite_rom_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .i_clk2(clk), .i_rst(rst), .i_req(req), .i_addr(addr_bus), .o_gnt(gnt),
    .o_rom_addr(rom_addr), .i_rom_data(rom_q), .o_rvalid(rvalid), .o_rdata(rdata), .o_err(err)
  );

  always #20 clk = ~clk;

  // Single-port ROM with registered output.
  always @(posedge clk) rom_q <= mem[rom_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; int k; logic [AW-1:0] addr; bit oob;} rsp_t;
  rsp_t pq[$];
  int   m_ptr = 0;
  int   m_cyc = 0;
  int   waitc [NREQ];
  logic [AW-1:0] m_rom = '0;
  logic [DW-1:0] m_last = '0;

  always @(negedge clk) begin
    logic [NREQ-1:0] eg, er;
    logic [DW-1:0]   ed;
    logic            ee;
    int              gk;
    rsp_t            r;
    if (rst) begin
      pq.delete();
      m_ptr = 0; m_rom = '0; m_last = '0;
      for (int k = 0; k < NREQ; k++) waitc[k] = 0;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rom_addr", 32'(rom_addr), 0);
      check("rst_rdata", 32'(rdata), 0);
    end else begin
      eg = '0; gk = -1;
      for (int off = 0; off < NREQ; off++) begin
        int k;
        k = (m_ptr + off) % NREQ;
        if (gk < 0 && req[k]) begin gk = k; eg[k] = 1'b1; end
      end
      check("m_gnt", 32'(gnt), 32'(eg));
      check("m_rom_addr", 32'(rom_addr), 32'(m_rom));
      if (pq.size() > 0 && pq[0].due == m_cyc) begin
        r = pq.pop_front();
        er = '0; er[r.k] = 1'b1;
        ed = r.oob ? '0 : mem[r.addr];
        ee = r.oob;
        m_last = ed;
      end else begin
        er = '0; ed = m_last; ee = 1'b0;
      end
      check("m_rvalid", 32'(rvalid), 32'(er));
      check("m_rdata", 32'(rdata), 32'(ed));
      check("m_err", 32'(err), 32'(ee));
      for (int k = 0; k < NREQ; k++) begin
        if (eg[k]) begin
          n_chk++;
          if (waitc[k] < NREQ) n_pass++;
          else $display("FAIL latency: req %0d waited %0d cycles, limit %0d", k, waitc[k] + 1, NREQ);
          waitc[k] = 0;
        end else if (req[k]) waitc[k]++;
        else waitc[k] = 0;
      end
      if (gk >= 0) begin
        r.due  = m_cyc + 2;
        r.k    = gk;
        r.addr = addr_bus[gk*AW +: AW];
        r.oob  = (int'(r.addr) >= DEPTH);
        pq.push_back(r);
        m_rom  = r.oob ? '0 : r.addr;
        m_ptr  = (gk + 1) % NREQ;
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  typedef struct {logic [NREQ-1:0] req; logic [NREQ-1:0] gnt;} vec_t;
  vec_t tbl [18];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input int a);
    addr_bus[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    for (int i = 0; i < 1024; i++) mem[i] = DW'((i * 37 + 11) ^ (i >> 4));

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b0101, 4'b0001};
    tbl[10] = '{4'b0100, 4'b0100};
    tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b1000, 4'b1000};
    tbl[13] = '{4'b0011, 4'b0001};
    tbl[14] = '{4'b0011, 4'b0010};
    tbl[15] = '{4'b0011, 4'b0001};
    tbl[16] = '{4'b1010, 4'b0010};
    tbl[17] = '{4'b0000, 4'b0000};

    repeat (2) next_cycle();
    rst = 1'b0;

    // Arbitration table straight out of reset (pointer at 0).
    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req;
      for (int k = 0; k < NREQ; k++) set_addr(k, i * 40 + k * 7);
      @(negedge clk);
      check($sformatf("tbl_gnt[%0d]", i), 32'(gnt), 32'(tbl[i].gnt));
      next_cycle();
    end
    req = '0;
    repeat (3) next_cycle();

    // Single read, requester 2, address 37.
    req = 4'b0100; set_addr(2, 37);
    @(negedge clk); check("single_gnt", 32'(gnt), 32'b0100);
    next_cycle(); req = '0;
    @(negedge clk); check("single_rom_addr", 32'(rom_addr), 37);
    next_cycle();
    @(negedge clk); check("single_rvalid", 32'(rvalid), 32'b0100);
    check("single_rdata", 32'(rdata), 32'(mem[37]));
    check("single_err", 32'(err), 0);
    next_cycle();
    @(negedge clk); check("idle_rvalid", 32'(rvalid), 0);
    check("idle_rdata_hold", 32'(rdata), 32'(mem[37]));
    next_cycle();

    // Out-of-range back-to-back on requester 1: 806, 1023, then 805.
    req = 4'b0010; set_addr(1, 806);
    @(negedge clk); check("oob_gnt", 32'(gnt), 32'b0010);
    next_cycle(); set_addr(1, 1023);
    @(negedge clk); check("oob806_rom_addr", 32'(rom_addr), 0);
    next_cycle(); set_addr(1, 805);
    @(negedge clk); check("oob1023_rom_addr", 32'(rom_addr), 0);
    check("oob806_rvalid", 32'(rvalid), 32'b0010);
    check("oob806_rdata", 32'(rdata), 0);
    check("oob806_err", 32'(err), 1);
    next_cycle(); req = '0;
    @(negedge clk); check("a805_rom_addr", 32'(rom_addr), 805);
    check("oob1023_rvalid", 32'(rvalid), 32'b0010);
    check("oob1023_rdata", 32'(rdata), 0);
    check("oob1023_err", 32'(err), 1);
    next_cycle();
    @(negedge clk); check("a805_rvalid", 32'(rvalid), 32'b0010);
    check("a805_rdata", 32'(rdata), 32'(mem[805]));
    check("a805_err", 32'(err), 0);
    next_cycle();

    // Reset in the middle of a burst.
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_addr(k, 100 + k);
    repeat (3) next_cycle();
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_rom_addr", 32'(rom_addr), 0);
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk); check("post_rst_gnt", 32'(gnt), 32'b0001);
    next_cycle(); req = '0;
    @(negedge clk); check("post_rst_no_stale", 32'(rvalid), 0);
    next_cycle();
    @(negedge clk); check("post_rst_rvalid", 32'(rvalid), 32'b0001);
    check("post_rst_rdata", 32'(rdata), 32'(mem[100]));
    next_cycle();

    // Random traffic obeying the hold-until-granted handshake.
    g = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!(req[k] && !g[k])) begin
          req[k] = ($urandom_range(0, 99) < 55);
          set_addr(k, int'($urandom_range(0, 1023)));
        end
      end
      @(negedge clk);
      g = gnt;
      next_cycle();
    end
    req = '0;
    repeat (4) next_cycle();
    @(negedge clk);
    check("drain_outstanding", 32'(pq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
